uart_rx_packet_ctrl: RTL and testbench

//  Sequences the byte stream from the UART receiver into framed packets:
//  [SOF][LEN][PAYLOAD x LEN][CSUM]. Validates length and checksum, buffers
//  the payload and hands it to the consumer through a show-ahead read port.

---
 rtl/uart_rx_packet_ctrl.sv | 175 +++++++++++++++++
 tb/tb_uart_rx_packet_ctrl.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_packet_ctrl.sv
// uart_rx_packet_ctrl: turns the UART byte stream into framed packets
// [SOF][LEN][PAYLOAD x LEN][CSUM]. It checks the length and the checksum,
// buffers the payload and offers it through a show-ahead read port.
// Optional build macro: UART_RX_PKT_TIMEOUT_EN adds an inter-byte timeout
// (err_code 5) while a packet is being received.
module uart_rx_packet_ctrl #(
  parameter int unsigned MAX_LEN     = 16,
  parameter logic [7:0]  SOF_BYTE    = 8'h7E,
  parameter int unsigned TIMEOUT_CYC = 104160
) (
  input  logic       CLOCK_50,
  input  logic       reset,
  input  logic [7:0] rx_data,
  input  logic       rx_valid,
  input  logic       rx_frame_err,
  input  logic       pkt_rd_en,
  output logic [7:0] pkt_data,
  output logic [4:0] pkt_len,
  output logic       pkt_ready,
  output logic       pkt_err,
  output logic [2:0] err_code,
  output logic       busy
);

  localparam int unsigned LEN_W = $clog2(MAX_LEN + 1);
  localparam int unsigned PTR_W = $clog2(MAX_LEN);

  localparam logic [2:0] E_LEN   = 3'd1;
  localparam logic [2:0] E_CSUM  = 3'd2;
  localparam logic [2:0] E_OVR   = 3'd3;
  localparam logic [2:0] E_FRAME = 3'd4;
  localparam logic [2:0] E_TMO   = 3'd5;

  typedef enum logic [2:0] {
    S_IDLE, S_LEN, S_PAYLOAD, S_CSUM, S_READY
  } state_t;

  state_t             r_state, w_state_nxt;
  logic [LEN_W-1:0]   r_len, w_len_nxt;
  logic [LEN_W-1:0]   r_wr_ptr, w_wr_nxt;
  logic [LEN_W-1:0]   r_rd_ptr, w_rd_nxt;
  logic [7:0]         r_sum, w_sum_nxt;
  logic [7:0]         w_sum_add;
  logic               w_buf_we;
  logic               w_err_set;
  logic [2:0]         w_err_code;
  logic               w_active;
  logic               w_tmo_hit;
  logic [7:0]         r_buf [MAX_LEN];

  assign w_active  = (r_state == S_LEN) || (r_state == S_PAYLOAD) || (r_state == S_CSUM);
  assign w_sum_add = r_sum + rx_data;

`ifdef UART_RX_PKT_TIMEOUT_EN
  localparam int unsigned TMO_W = $clog2(TIMEOUT_CYC + 1);
  logic [TMO_W-1:0] r_tmo_cnt;

  assign w_tmo_hit = w_active && !rx_valid && (r_tmo_cnt == TMO_W'(TIMEOUT_CYC - 1));

  // Inter-byte idle counter; only runs while a packet is in flight
  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset)                                  r_tmo_cnt <= '0;
    else if (!w_active || rx_valid || w_tmo_hit) r_tmo_cnt <= '0;
    else                                        r_tmo_cnt <= r_tmo_cnt + TMO_W'(1);
  end
`else
  assign w_tmo_hit = 1'b0;
  if (TIMEOUT_CYC == 0) begin : g_tmo_unused
  end
`endif

  // Next-state, datapath updates and error reporting
  always_comb begin
    w_state_nxt = r_state;
    w_len_nxt   = r_len;
    w_wr_nxt    = r_wr_ptr;
    w_rd_nxt    = r_rd_ptr;
    w_sum_nxt   = r_sum;
    w_buf_we    = 1'b0;
    w_err_set   = 1'b0;
    w_err_code  = err_code;
    if (w_active && rx_frame_err) begin
      w_err_set   = 1'b1;
      w_err_code  = E_FRAME;
      w_state_nxt = S_IDLE;
    end else if (w_tmo_hit) begin
      w_err_set   = 1'b1;
      w_err_code  = E_TMO;
      w_state_nxt = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (rx_valid && !rx_frame_err && (rx_data == SOF_BYTE)) w_state_nxt = S_LEN;
        end
        S_LEN: begin
          if (rx_valid) begin
            if ((rx_data == 8'd0) || (rx_data > 8'(MAX_LEN))) begin
              w_err_set   = 1'b1;
              w_err_code  = E_LEN;
              w_state_nxt = S_IDLE;
            end else begin
              w_len_nxt   = LEN_W'(rx_data);
              w_wr_nxt    = '0;
              w_sum_nxt   = '0;
              w_state_nxt = S_PAYLOAD;
            end
          end
        end
        S_PAYLOAD: begin
          if (rx_valid) begin
            w_buf_we  = 1'b1;
            w_sum_nxt = w_sum_add;
            w_wr_nxt  = r_wr_ptr + LEN_W'(1);
            if (r_wr_ptr == r_len - LEN_W'(1)) w_state_nxt = S_CSUM;
          end
        end
        S_CSUM: begin
          if (rx_valid) begin
            if (w_sum_add == 8'd0) begin
              w_rd_nxt    = '0;
              w_state_nxt = S_READY;
            end else begin
              w_err_set   = 1'b1;
              w_err_code  = E_CSUM;
              w_state_nxt = S_IDLE;
            end
          end
        end
        S_READY: begin
          if (pkt_rd_en) begin
            w_rd_nxt = r_rd_ptr + LEN_W'(1);
            if (r_rd_ptr == r_len - LEN_W'(1)) w_state_nxt = S_IDLE;
          end
          if (rx_valid && !rx_frame_err) begin
            w_err_set  = 1'b1;
            w_err_code = E_OVR;
          end
        end
        default: w_state_nxt = S_IDLE;
      endcase
    end
  end

  // State, pointers, checksum and error registers
  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      r_state  <= S_IDLE;
      r_len    <= '0;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_sum    <= '0;
      pkt_err  <= 1'b0;
      err_code <= 3'd0;
    end else begin
      r_state  <= w_state_nxt;
      r_len    <= w_len_nxt;
      r_wr_ptr <= w_wr_nxt;
      r_rd_ptr <= w_rd_nxt;
      r_sum    <= w_sum_nxt;
      pkt_err  <= w_err_set;
      err_code <= w_err_code;
    end
  end

  // Payload buffer; contents are only visible through the READY gating below
  always_ff @(posedge CLOCK_50) begin
    if (w_buf_we) r_buf[r_wr_ptr[PTR_W-1:0]] <= rx_data;
  end

  assign pkt_ready = (r_state == S_READY);
  assign busy      = (r_state != S_IDLE);
  assign pkt_len   = pkt_ready ? 5'(r_len) : 5'd0;
  assign pkt_data  = pkt_ready ? r_buf[r_rd_ptr[PTR_W-1:0]] : 8'd0;

endmodule

// File: tb/tb_uart_rx_packet_ctrl.sv
// Directed bench for uart_rx_packet_ctrl with a payload scoreboard queue.
module tb_uart_rx_packet_ctrl;

  localparam int unsigned TO = 200;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_frame_err;
  logic       pkt_rd_en;
  logic [7:0] pkt_data;
  logic [4:0] pkt_len;
  logic       pkt_ready;
  logic       pkt_err;
  logic [2:0] err_code;
  logic       busy;

  int n_checks = 0;
  int n_fail   = 0;
  logic [7:0] sb_q[$];

  uart_rx_packet_ctrl #(.MAX_LEN(16), .SOF_BYTE(8'h7E), .TIMEOUT_CYC(TO)) dut (
    .CLOCK_50(clk), .reset(rst), .rx_data(rx_data), .rx_valid(rx_valid),
    .rx_frame_err(rx_frame_err), .pkt_rd_en(pkt_rd_en), .pkt_data(pkt_data),
    .pkt_len(pkt_len), .pkt_ready(pkt_ready), .pkt_err(pkt_err),
    .err_code(err_code), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [7:0] b, input logic fe);
    @(negedge clk);
    rx_data = b; rx_valid = 1'b1; rx_frame_err = fe;
    @(negedge clk);
    rx_valid = 1'b0; rx_frame_err = 1'b0;
  endtask

  // Sends a well-formed packet and queues its payload as expected output
  task automatic send_pkt(input logic [7:0] pl[$]);
    logic [7:0] s;
    s = 8'd0;
    send(8'h7E, 1'b0);
    send(8'(pl.size()), 1'b0);
    foreach (pl[i]) begin
      send(pl[i], 1'b0);
      s = s + pl[i];
      sb_q.push_back(pl[i]);
    end
    send(8'd0 - s, 1'b0);
  endtask

  task automatic pop_check(input int n, input string tag);
    logic [7:0] e;
    for (int i = 0; i < n; i++) begin
      chk({tag, "_ready"}, 32'(pkt_ready), 32'd1);
      e = (sb_q.size() > 0) ? sb_q.pop_front() : 8'hXX;
      chk({tag, "_data"}, 32'(pkt_data), 32'(e));
      pkt_rd_en = 1'b1;
      @(negedge clk);
      pkt_rd_en = 1'b0;
    end
    chk({tag, "_ready_after"}, 32'(pkt_ready), 32'd0);
    chk({tag, "_busy_after"}, 32'(busy), 32'd0);
  endtask

  initial begin
    logic [7:0] pl[$];
    rst = 1'b1; rx_data = 8'd0; rx_valid = 1'b0; rx_frame_err = 1'b0; pkt_rd_en = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_ready", 32'(pkt_ready), 32'd0);
    chk("rst_err", 32'(pkt_err), 32'd0);
    chk("rst_code", 32'(err_code), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_len", 32'(pkt_len), 32'd0);
    chk("rst_data", 32'(pkt_data), 32'd0);
    rst = 1'b0;

    // Pop strobe while idle must have no effect
    pkt_rd_en = 1'b1; @(negedge clk); pkt_rd_en = 1'b0;

    // 1: basic packet, checksum byte must be 9A
    pl = '{8'h11, 8'h22, 8'h33};
    send_pkt(pl);
    chk("t1_ready", 32'(pkt_ready), 32'd1);
    chk("t1_len", 32'(pkt_len), 32'd3);
    chk("t1_busy", 32'(busy), 32'd1);
    pop_check(3, "t1");

    // 2: bad checksum
    send(8'h7E, 1'b0); send(8'h03, 1'b0);
    send(8'h11, 1'b0); send(8'h22, 1'b0); send(8'h33, 1'b0);
    send(8'h9B, 1'b0);
    chk("t2_err_pulse", 32'(pkt_err), 32'd1);
    chk("t2_code", 32'(err_code), 32'd2);
    chk("t2_ready", 32'(pkt_ready), 32'd0);
    @(negedge clk);
    chk("t2_err_low", 32'(pkt_err), 32'd0);
    chk("t2_code_hold", 32'(err_code), 32'd2);
    chk("t2_busy", 32'(busy), 32'd0);

    // 3: length boundaries 0, 17 rejected; 16 accepted
    send(8'h7E, 1'b0);
    chk("t3_busy_sof", 32'(busy), 32'd1);
    send(8'h00, 1'b0);
    chk("t3_len0_code", 32'(err_code), 32'd1);
    chk("t3_len0_busy", 32'(busy), 32'd0);
    send(8'h7E, 1'b0); send(8'h11, 1'b0);
    chk("t3_len17_code", 32'(err_code), 32'd1);
    chk("t3_len17_err", 32'(pkt_err), 32'd1);
    chk("t3_len17_busy", 32'(busy), 32'd0);
    pl = {};
    for (int i = 0; i < 16; i++) pl.push_back(8'(8'h7E + i * 13));
    send_pkt(pl);
    chk("t3_len16_len", 32'(pkt_len), 32'd16);
    pop_check(16, "t3_max");

    // 4: overrun while holding, then pop combined with an incoming byte
    pl = '{8'h11, 8'h22, 8'h33};
    send_pkt(pl);
    send(8'h55, 1'b0);
    chk("t4_ovr_err", 32'(pkt_err), 32'd1);
    chk("t4_ovr_code", 32'(err_code), 32'd3);
    chk("t4_ovr_ready", 32'(pkt_ready), 32'd1);
    chk("t4_pop0", 32'(pkt_data), 32'(sb_q.pop_front()));
    @(negedge clk);
    rx_data = 8'h66; rx_valid = 1'b1; pkt_rd_en = 1'b1;
    @(negedge clk);
    rx_valid = 1'b0; pkt_rd_en = 1'b0;
    chk("t4_both_err", 32'(pkt_err), 32'd1);
    chk("t4_both_code", 32'(err_code), 32'd3);
    pop_check(2, "t4");

    // 5: junk before SOF, then a frame error mid-packet
    send(8'hAA, 1'b0); send(8'h55, 1'b0);
    chk("t5_junk_busy", 32'(busy), 32'd0);
    chk("t5_junk_err", 32'(pkt_err), 32'd0);
    pl = '{8'h01, 8'h02};
    send_pkt(pl);
    chk("t5_len", 32'(pkt_len), 32'd2);
    pop_check(2, "t5");
    send(8'h7E, 1'b0); send(8'h02, 1'b0); send(8'h01, 1'b1);
    chk("t5_fe_err", 32'(pkt_err), 32'd1);
    chk("t5_fe_code", 32'(err_code), 32'd4);
    chk("t5_fe_busy", 32'(busy), 32'd0);

    // 6: inter-byte stall
    send(8'h7E, 1'b0); send(8'h02, 1'b0);
`ifdef UART_RX_PKT_TIMEOUT_EN
    repeat (TO + 5) @(negedge clk);
    chk("t6_tmo_code", 32'(err_code), 32'd5);
    chk("t6_tmo_busy", 32'(busy), 32'd0);
`else
    repeat (TO + 50) @(negedge clk);
    chk("t6_stall_busy", 32'(busy), 32'd1);
    chk("t6_stall_code", 32'(err_code), 32'd4);
    send(8'h10, 1'b0); send(8'h20, 1'b0); send(8'hD0, 1'b0);
    sb_q.push_back(8'h10); sb_q.push_back(8'h20);
    chk("t6_len", 32'(pkt_len), 32'd2);
    pop_check(2, "t6");
`endif

    // 7: reset mid-payload, then a clean packet
    send(8'h7E, 1'b0); send(8'h04, 1'b0); send(8'hAA, 1'b0); send(8'hBB, 1'b0);
    chk("t7_busy_pre", 32'(busy), 32'd1);
    rst = 1'b1;
    #1;
    chk("t7_rst_busy", 32'(busy), 32'd0);
    chk("t7_rst_code", 32'(err_code), 32'd0);
    chk("t7_rst_ready", 32'(pkt_ready), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    pl = '{8'hC3, 8'h7E, 8'h00};
    send_pkt(pl);
    chk("t7_len", 32'(pkt_len), 32'd3);
    chk("t7_code", 32'(err_code), 32'd0);
    pop_check(3, "t7");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
